// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffer.
package pipe_pkg;

   localparam int unsigned WB_W   = 2;
   localparam int unsigned M_W    = 4;
   localparam int unsigned EX_W   = 5;
   localparam int unsigned CTRL_W = WB_W + M_W + EX_W;

   // Encoding matches the number of words held, so occupancy is a direct cast.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   typedef logic [1:0] occupancy_t;

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake, payload, flush and statistics bundle for one pipeline boundary.
interface pipe_stage_buf_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
   parameter int unsigned CNT_W  = 16
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              flush;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   // Side that drives words in and consumes them (pipeline / bench).
   modport master (
      output in_valid, in_data, in_ctrl, out_ready, flush,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt, flush_cnt
   );

   // The buffer itself.
   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready, flush,
      output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry elastic pipeline register with flush and bubble insertion.
// Define PIPE_STAGE_BUF_STATS_EN to build the stall/flush statistics counters.
module pipe_stage_buf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
   parameter int unsigned CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   pipe_stage_buf_if.slave bus
);

   import pipe_pkg::*;

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
   logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic              in_ready_c, out_valid_c, in_fire_c, out_fire_c;

   // Handshake is a pure function of the state register.
   assign in_ready_c  = (state_q != FULL);
   assign out_valid_c = (state_q != EMPTY);
   assign in_fire_c   = bus.in_valid & in_ready_c;
   assign out_fire_c  = out_valid_c & bus.out_ready;

   // Next-state and storage steering.
   always_comb begin
      state_d  = state_q;
      h_data_d = h_data_q;
      h_ctrl_d = h_ctrl_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire_c) begin
                  state_d  = ONE;
                  h_data_d = bus.in_data;
                  h_ctrl_d = bus.in_ctrl;
               end
            end
            ONE: begin
               if (in_fire_c && out_fire_c) begin
                  h_data_d = bus.in_data;
                  h_ctrl_d = bus.in_ctrl;
               end else if (in_fire_c) begin
                  state_d  = FULL;
                  s_data_d = bus.in_data;
                  s_ctrl_d = bus.in_ctrl;
               end else if (out_fire_c) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire_c) begin
                  state_d  = ONE;
                  h_data_d = s_data_q;
                  h_ctrl_d = s_ctrl_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         h_data_q <= '0;
         h_ctrl_q <= '0;
         s_data_q <= '0;
         s_ctrl_q <= '0;
      end else begin
         state_q  <= state_d;
         h_data_q <= h_data_d;
         h_ctrl_q <= h_ctrl_d;
         s_data_q <= s_data_d;
         s_ctrl_q <= s_ctrl_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = h_data_q;
   assign bus.out_ctrl  = out_valid_c ? h_ctrl_q : CTRL_W'(CTRL_BUBBLE);
   assign bus.occupancy = occupancy_t'(state_q);

`ifdef PIPE_STAGE_BUF_STATS_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid_c & ~bus.out_ready),
      .count (bus.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.flush),
      .count (bus.flush_cnt)
   );
`else
   assign bus.stall_cnt = CNT_W'(0);
   assign bus.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Generic elastic pipeline-stage buffer that replaces the fixed, free-running IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries a wide datapath payload plus a separate control field (WB/M/EX bits).
- Adds valid/ready back-pressure, a 2-entry skid for full throughput, synchronous flush and bubble insertion.
- Instantiated once per pipeline boundary, with widths set per stage.

Parameters:
DATA_W, 32, payload width in bits (concatenated datapath fields).
CTRL_W, 11, control field width (default 2 WB + 4 M + 5 EX).
CNT_W, 16, width of statistics counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
in_valid  in  1  upstream has a word
in_ready  out  1  stage can accept; in_fire = in_valid & in_ready
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  head word valid
out_ready  in  1  downstream accepts; out_fire = out_valid & out_ready
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control; all-zero (bubble) when out_valid=0
flush  in  1  discard all held words and the incoming word this cycle
occupancy  out  2  words held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
flush_cnt  out  CNT_W  cycles with flush asserted

Behaviour:
- Storage: head register H (data, ctrl) and skid register S (data, ctrl).
- State enum: EMPTY (occupancy 0), ONE (H valid, occupancy 1), FULL (H and S valid, occupancy 2).
- in_ready = (state != FULL). It is derived only from the state register, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data = H.data. out_ctrl = out_valid ? H.ctrl : '0.
- Transitions when rst=0 and flush=0:
  - EMPTY: in_fire -> ONE, H <= in.
  - ONE: in_fire & out_fire -> ONE, H <= in. in_fire only -> FULL, S <= in. out_fire only -> EMPTY. Neither -> hold.
  - FULL: out_fire -> ONE, H <= S. Otherwise hold.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush.
- Latency: word accepted at edge N is presented on out_* after edge N (1 cycle). Throughput is 1 word/cycle when out_ready is held high.
- Flush (priority below rst, above everything else):
  - Next state is EMPTY.
  - A word offered with in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
  - H and S contents need not be cleared. out_ctrl reads zero because out_valid=0.
- Reset (rst high at edge):
  - state EMPTY, H and S cleared to 0, stall_cnt and flush_cnt cleared to 0.
  - Post-reset outputs: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_valid is ignored while rst=1. Reset mid-operation drops all held words.
- Counters saturate at 2^CNT_W-1 and never wrap.
  - stall_cnt increments in cycles with out_valid & !out_ready & !rst.
  - flush_cnt increments in cycles with flush & !rst.
- Inputs are sampled only at rising clk. All outputs are glitch-free functions of registers.

Optional Feature:
PIPE_STAGE_BUF_STATS_EN
- Defined: stall_cnt and flush_cnt are implemented as specified.
- Undefined: both ports remain present and are tied to constant 0. No counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg:
  - typedef pipe_state_e {EMPTY, ONE, FULL}
  - constants WB_W=2, M_W=4, EX_W=5, CTRL_W=WB_W+M_W+EX_W
  - typedef occupancy_t (2 bits)
  - constant CTRL_BUBBLE='0
- One sub-module: sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated twice under the macro.

Test Plan:
1. Reset then streaming: rst for 2 cycles, then in_valid=1 with in_data 0x1..0x8 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready stays 1, occupancy stays 1.
2. Back-pressure: out_ready=0 while sending 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order, no loss.
3. Flush with in_fire: occupancy=2 holding 0x10/0x11, flush=1 while offering 0x12 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x12 never appears at the output.
4. Bubble control: in_ctrl=0x7FF accepted, out_ready=1, no further input -> out_ctrl=0x7FF for one cycle, then 0x000 with out_valid=0.
5. Reset mid-operation: occupancy=2, rst=1 for 1 cycle -> out_valid=0, out_data=0, in_ready=1, counters=0. The next accepted word is emitted first.
6. Statistics (macro defined, CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Pulse flush 3 times -> flush_cnt=3. With the macro undefined, both counters read 0 throughout.
